// File: rtl/cachemodel_pkg.sv
// Shared definitions for the cachemodel memory model: FSM state encoding and
// the latency-counter width helper.
package cachemodel_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Counter must hold MISS_LAT-1, the longest preload value.
  function automatic int cnt_width(input int miss_lat);
    return $clog2(miss_lat) + 1;
  endfunction

endpackage

// File: rtl/cachemodel_tags.sv
// Direct-mapped tag array used for hit/miss timing. Lookup is combinational
// on the live request address; install writes the tag of the latched address.
module cachemodel_tags #(
  parameter int ADDR_W     = 30,
  parameter int LINES_LOG2 = 6
) (
  input  logic              ph1,
  input  logic              resetb,
  input  logic [ADDR_W-1:0] lookup_adr,
  output logic              lookup_hit,
  input  logic              install,
  input  logic [ADDR_W-1:0] install_adr
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = ADDR_W - LINES_LOG2;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tagr [LINES];
  logic [LINES_LOG2-1:0] lk_idx;
  logic [LINES_LOG2-1:0] in_idx;

  assign lk_idx     = lookup_adr[LINES_LOG2-1:0];
  assign in_idx     = install_adr[LINES_LOG2-1:0];
  assign lookup_hit = valid[lk_idx] && (tagr[lk_idx] == lookup_adr[ADDR_W-1:LINES_LOG2]);

  // Valid bits are control state: cleared on reset, set on install.
  always_ff @(posedge ph1) begin
    if (!resetb) valid <= '0;
    else if (install) valid[in_idx] <= 1'b1;
  end

  // Tag storage is data: not reset; an install coinciding with reset is dropped.
  always_ff @(posedge ph1) begin
    if (resetb && install) tagr[in_idx] <= install_adr[ADDR_W-1:LINES_LOG2];
  end

endmodule

// File: rtl/cachemodel.sv
// Latency-accurate memory model behind the processor port handshake.
// Optional hit/miss timing with a direct-mapped tag array is enabled by
// defining CACHEMODEL_MISS_EN; otherwise every access takes HIT_LAT cycles.
module cachemodel import cachemodel_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int DEPTH_LOG2 = 10,
  parameter int HIT_LAT    = 1,
  parameter int MISS_LAT   = 8,
  parameter int LINES_LOG2 = 6
) (
  input  logic                ph1,
  input  logic                resetb,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] byteen,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                busy,
  output logic                hit
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = cnt_width(MISS_LAT);
  localparam logic [CNT_W-1:0] HIT_M1  = CNT_W'(HIT_LAT - 1);
  localparam logic [CNT_W-1:0] MISS_M1 = CNT_W'(MISS_LAT - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [ADDR_W-1:0]     adr_q;
  logic                  we_q;
  logic                  miss_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [NB-1:0]         byteen_q;
  logic [DATA_W-1:0]     mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  finish;
  logic                  lookup_hit;

  assign idx    = adr_q[DEPTH_LOG2-1:0];
  assign accept = (state == S_IDLE) && req;
  assign finish = (state == S_WAIT) && (cnt == '0);
  assign ack    = (state == S_ACK);
  assign busy   = (state != S_IDLE);

`ifdef CACHEMODEL_MISS_EN
  cachemodel_tags #(
    .ADDR_W     (ADDR_W),
    .LINES_LOG2 (LINES_LOG2)
  ) u_tags (
    .ph1         (ph1),
    .resetb      (resetb),
    .lookup_adr  (adr),
    .lookup_hit  (lookup_hit),
    .install     (finish && miss_q),
    .install_adr (adr_q)
  );
`else
  localparam int unused_lines = LINES_LOG2;
  logic unused_adr;
  assign unused_adr = ^adr_q;
  assign lookup_hit = 1'b1;
`endif

  // State and latency counter registers.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle ACK.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_WAIT;
          cnt_nxt   = lookup_hit ? HIT_M1 : MISS_M1;
        end
      end
      S_WAIT: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture at accept; the requester holds inputs stable anyway.
  always_ff @(posedge ph1) begin
    if (accept) begin
      adr_q    <= adr;
      we_q     <= we;
      wdata_q  <= wdata;
      byteen_q <= byteen;
      miss_q   <= !lookup_hit;
    end
  end

  // Storage write on the ACK transition; a write caught by reset is dropped.
  always_ff @(posedge ph1) begin
    if (resetb && finish && we_q) begin
      for (int b = 0; b < NB; b++) begin
        if (byteen_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  // Read data and hit flag, updated on the ACK transition and held until the next.
  always_ff @(posedge ph1) begin
    if (!resetb) begin
      rdata <= '0;
      hit   <= 1'b0;
    end else if (finish) begin
      if (!we_q) rdata <= mem[idx];
      hit <= !miss_q;
    end
  end

endmodule

// File: tb/tb_cachemodel.sv
// Self-checking bench for cachemodel: directed scenarios plus randomized
// accesses compared against a word-array / tag-map reference model.
module tb_cachemodel;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 30;
  localparam int DEPTH_LOG2 = 10;
  localparam int HIT_LAT    = 1;
  localparam int MISS_LAT   = 8;
  localparam int LINES_LOG2 = 6;
  localparam int NB         = DATA_W / 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LINES      = 1 << LINES_LOG2;
  localparam int TMO        = 40;

  logic              ph1 = 1'b0;
  logic              resetb;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     byteen;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              hit;

  int total = 0;
  int bad   = 0;

  // Reference model: memory words keyed by aliased index, tags keyed by line.
  logic [DATA_W-1:0] mdl [int];
  int                tagm [int];
  logic [DATA_W-1:0] rdata_exp;
  bit                rdata_known;

  cachemodel #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH_LOG2 (DEPTH_LOG2),
    .HIT_LAT (HIT_LAT), .MISS_LAT (MISS_LAT), .LINES_LOG2 (LINES_LOG2)
  ) dut (
    .ph1 (ph1), .resetb (resetb), .req (req), .we (we), .adr (adr),
    .wdata (wdata), .byteen (byteen), .rdata (rdata), .ack (ack),
    .busy (busy), .hit (hit)
  );

  always #5 ph1 = ~ph1;

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
`ifdef CACHEMODEL_MISS_EN
    int li;
    int tg;
    li = int'(a) % LINES;
    tg = int'(a) / LINES;
    return tagm.exists(li) && (tagm[li] == tg);
`else
    return (a === a);
`endif
  endfunction

  function automatic void model_access(input logic w, input logic [ADDR_W-1:0] a,
                                       input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    int i;
    logic [DATA_W-1:0] word;
    i = int'(a) % DEPTH;
    if (w) begin
      word = mdl.exists(i) ? mdl[i] : '0;
      for (int b = 0; b < NB; b++) if (be[b]) word[b*8 +: 8] = d[b*8 +: 8];
      mdl[i] = word;
    end else begin
      rdata_known = mdl.exists(i);
      if (rdata_known) rdata_exp = mdl[i];
    end
`ifdef CACHEMODEL_MISS_EN
    tagm[int'(a) % LINES] = int'(a) / LINES;
`endif
  endfunction

  // One complete handshake with latency, hit, busy and data checks.
  task automatic do_access(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [NB-1:0] be, input string nm,
                           output int lat_seen, output logic hit_seen);
    bit   ehit;
    int   elat;
    int   n;
    ehit = model_hit(a);
    elat = ehit ? HIT_LAT : MISS_LAT;
    req = 1'b1; we = w; adr = a; wdata = d; byteen = be;
    @(posedge ph1); #1;
    n = 0;
    while (ack !== 1'b1 && n < TMO) begin @(posedge ph1); #1; n++; end
    req = 1'b0;
    lat_seen = n;
    hit_seen = hit;
    model_access(w, a, d, be);
    total++;
    if (n !== elat) begin bad++; $display("FAIL %s latency: got %0d want %0d", nm, n, elat); end
    total++;
    if (hit !== ehit) begin bad++; $display("FAIL %s hit: got %b want %b", nm, hit, ehit); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_at_ack: got %b want 1", nm, busy); end
    if (rdata_known) begin
      total++;
      if (rdata !== rdata_exp) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, rdata, rdata_exp); end
    end
    @(posedge ph1); #1;
    total++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after_ack: got ack=%b busy=%b want 0 0", nm, ack, busy);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0; req = 1'b0; we = 1'b0; adr = '0; wdata = '0; byteen = '0;
    repeat (2) @(posedge ph1);
    #1;
    total++;
    if (ack !== 1'b0 || busy !== 1'b0 || hit !== 1'b0 || rdata !== '0) begin
      bad++; $display("FAIL reset: got ack=%b busy=%b hit=%b rdata=%h want all 0", ack, busy, hit, rdata);
    end
    tagm.delete();
    rdata_exp = '0; rdata_known = 1'b1;
    resetb = 1'b1;
    @(posedge ph1); #1;
  endtask

  task automatic test_basic_byteen();
    int l; logic h;
    do_access(1'b1, 30'd5, 32'hDEADBEEF, 4'hF, "wr5", l, h);
    do_access(1'b0, 30'd5, '0, 4'h0, "rd5", l, h);
    total++;
    if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd5_const: got %h want deadbeef", rdata); end
    do_access(1'b1, 30'd5, 32'h0000AA00, 4'b0010, "wr5_lane1", l, h);
    do_access(1'b0, 30'd5, '0, 4'hF, "rd5_lane1", l, h);
    total++;
    if (rdata !== 32'hDEADAAEF) begin bad++; $display("FAIL byteen_const: got %h want deadaaef", rdata); end
  endtask

  task automatic test_alias();
    int l; logic h;
    do_access(1'b0, 30'd5 + 30'(DEPTH), '0, 4'h0, "rd_alias", l, h);
    total++;
    if (rdata !== 32'hDEADAAEF) begin bad++; $display("FAIL alias_const: got %h want deadaaef", rdata); end
  endtask

  task automatic test_held_req();
    int lat1, lat2, e1, e2, nacks, first, second;
    lat1 = model_hit(30'd5) ? HIT_LAT : MISS_LAT;
    model_access(1'b0, 30'd5, '0, '0);
    lat2 = model_hit(30'd5) ? HIT_LAT : MISS_LAT;
    e1 = lat1;
    e2 = lat1 + 2 + lat2;
    nacks = 0; first = -1; second = -1;
    req = 1'b1; we = 1'b0; adr = 30'd5; byteen = '0;
    @(posedge ph1); #1;
    for (int n = 1; n <= e2 + 1; n++) begin
      if (n == e2 + 1) req = 1'b0;
      @(posedge ph1); #1;
      if (ack === 1'b1) begin
        nacks++;
        if (first < 0) first = n; else if (second < 0) second = n;
      end
    end
    req = 1'b0;
    total++;
    if (first !== e1 || second !== e2 || nacks !== 2) begin
      bad++; $display("FAIL held_req: got acks=%0d at %0d,%0d want 2 at %0d,%0d", nacks, first, second, e1, e2);
    end
    total++;
    if (rdata !== rdata_exp) begin bad++; $display("FAIL held_req_rdata: got %h want %h", rdata, rdata_exp); end
    repeat (2) @(posedge ph1);
    #1;
  endtask

  task automatic test_reset_mid_write();
    int l; logic h;
    do_access(1'b1, 30'd7, 32'hCAFEF00D, 4'hF, "wr7_prior", l, h);
    req = 1'b1; we = 1'b1; adr = 30'd7; wdata = 32'h12345678; byteen = 4'hF;
    @(posedge ph1); #1;
    resetb = 1'b0; req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge ph1); #1;
      total++;
      if (ack !== 1'b0) begin bad++; $display("FAIL reset_mid_ack: got %b want 0", ack); end
    end
    total++;
    if (busy !== 1'b0 || hit !== 1'b0 || rdata !== '0) begin
      bad++; $display("FAIL reset_mid_out: got busy=%b hit=%b rdata=%h want 0", busy, hit, rdata);
    end
    tagm.delete();
    rdata_exp = '0; rdata_known = 1'b1;
    resetb = 1'b1;
    @(posedge ph1); #1;
    do_access(1'b0, 30'd7, '0, 4'h0, "rd7_after_reset", l, h);
    total++;
    if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL reset_mid_keep: got %h want cafef00d", rdata); end
  endtask

`ifdef CACHEMODEL_MISS_EN
  task automatic test_miss();
    int l; logic h;
    int addrs [4] = '{32'h40, 32'h40, 32'h80, 32'h40};
    int lats  [4] = '{MISS_LAT, HIT_LAT, MISS_LAT, MISS_LAT};
    test_reset();
    for (int i = 0; i < 4; i++) begin
      do_access(1'b0, 30'(addrs[i]), '0, 4'h0, "miss_seq", l, h);
      total++;
      if (l !== lats[i] || h !== (lats[i] == HIT_LAT)) begin
        bad++; $display("FAIL miss_seq%0d: got lat=%0d hit=%b want lat=%0d", i, l, h, lats[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int l; logic h;
    logic w;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 40; i++) begin
      a = ADDR_W'($urandom_range(0, 15)) + ADDR_W'($urandom_range(0, 3) * DEPTH)
        + ADDR_W'($urandom_range(0, 1) * LINES);
      w = 1'($urandom_range(0, 1));
      if (!mdl.exists(int'(a) % DEPTH)) w = 1'b1;
      do_access(w, a, DATA_W'($urandom), NB'($urandom_range(0, 15)), "random", l, h);
    end
  endtask

  initial begin
    test_reset();
    test_basic_byteen();
    test_alias();
    test_held_req();
    test_reset_mid_write();
`ifdef CACHEMODEL_MISS_EN
    test_miss();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cachemodel.md
# cachemodel

Parametrised, latency-accurate memory model behind the processor's instruction- and data-port handshake, replacing the fixed-delay ideal cache in simulation tops. Handles word reads and byte-enabled writes with a configurable response latency and a single-cycle ack pulse. Optionally models hit/miss timing with a direct-mapped tag array. Sits between the `mips` port (pc or dataadr word address, writedata, byteen) and the `top` level.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 30: word-address width.
- `DEPTH_LOG2`, 10: log2 of storage words.
- `HIT_LAT`, 1: access latency in cycles; ≥1.
- `MISS_LAT`, 8: miss latency in cycles; ≥`HIT_LAT`; used only with the macro.
- `LINES_LOG2`, 6: log2 of tag entries; used only with the macro.

Ports:
- `ph1`  in  1  clock; all state updates on the rising edge.
- `resetb`  in  1  synchronous, active-low reset.
- `req`  in  1  access request; held with `we`/`adr`/`wdata`/`byteen` stable until `ack`.
- `we`  in  1  1 = write, 0 = read.
- `adr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `byteen`  in  DATA_W/8  byte enables for writes; ignored on reads.
- `rdata`  out  DATA_W  read data; valid in the `ack` cycle, held until the next `ack`.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while in WAIT or ACK.
- `hit`  out  1  hit flag, valid with `ack`.

## Operation
- FSM states and transitions:
  - IDLE: `req`=1 → WAIT, load `cnt` with LAT−1, latch `adr`, `we`, `wdata`, `byteen`.
  - WAIT: `cnt`≠0 → decrement `cnt`; `cnt`=0 → ACK.
  - ACK: → IDLE unconditionally.
- Transition into ACK does the following:
  - Writes RAM[idx] byte lanes where `byteen` is 1; idx = latched `adr[DEPTH_LOG2-1:0]`.
  - On a read, captures `rdata` = RAM[idx].
  - Sets `ack`=1 for exactly one cycle.
- Addresses alias modulo 2^DEPTH_LOG2. Upper address bits are ignored for storage.
- `req` still high during ACK or the following IDLE edge:
  - Not a new request in the ACK cycle.
  - Accepted as a new request at the IDLE edge.
  - Requester deasserts `req` in the ack cycle to avoid a repeat.
- Reads return the full word. A write followed by a read to the same idx returns the written data.
- Reset, including mid-operation:
  - FSM → IDLE; `ack`, `busy`, `hit`, `rdata` = 0.
  - An in-flight write is dropped and RAM is not modified.
  - RAM contents are not reset.

## Timing
- Request sampled at edge k. `ack` rises at edge k+LAT and falls at k+LAT+1.
- Next request is accepted no earlier than edge k+LAT+2. Throughput is one access per LAT+2 cycles.
- LAT = `HIT_LAT`, or `MISS_LAT` on a miss when the macro is defined.
- `busy` rises at edge k+1 and falls at k+LAT+1.
- `cnt` width = clog2(MISS_LAT)+1.

## Configuration
- `CACHEMODEL_MISS_EN` defined:
  - Direct-mapped tag array: 2^LINES_LOG2 entries, each a valid bit plus tag `adr[ADDR_W-1:LINES_LOG2]`.
  - Lookup at accept. Hit → LAT=`HIT_LAT`, `hit`=1 at ack. Miss → LAT=`MISS_LAT`, `hit`=0.
  - On a miss, the tag is installed at the ACK transition; reads and writes both allocate.
  - Reset clears all valid bits.
- `CACHEMODEL_MISS_EN` undefined:
  - No tag array.
  - Every access uses `HIT_LAT`; `hit`=1 with every `ack`.

## Structure
- Package `cachemodel_pkg` holds:
  - FSM state enum (IDLE/WAIT/ACK).
  - Latency-counter width helper function.
- Sub-module `cachemodel_tags` holds the tag array, lookup and install. It is instantiated only under `CACHEMODEL_MISS_EN`.

## Test plan
- Reset: hold `resetb`=0 for 2 cycles → `ack`=0, `busy`=0, `hit`=0, `rdata`=0.
- Basic write/read, HIT_LAT=1: write 32'hDEADBEEF to `adr`=5 with `byteen`=4'hF → `ack` at k+1 only. Then read `adr`=5 → `rdata`=32'hDEADBEEF.
- Byte enables: write 32'h0000AA00 with `byteen`=4'b0010 to `adr`=5 → later read gives 32'hDEADAAEF.
- Miss timing (macro defined, HIT_LAT=1, MISS_LAT=8, LINES_LOG2=6):
  - First read `adr`=32'h40 → `ack` at k+8, `hit`=0.
  - Repeat → `ack` at k+1, `hit`=1.
  - Read `adr`=32'h80 → miss.
  - Read `adr`=32'h40 again → miss (same index evicted).
- Reset mid-write: assert `resetb`=0 during WAIT of a write of 32'h12345678 to `adr`=7 → no `ack`; later read of `adr`=7 returns the prior value.
- Held request and aliasing: keep `req` high across `ack` → acks at k+LAT and k+2LAT+2 only. Read `adr`=5+2^DEPTH_LOG2 → same data as `adr`=5.
